// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//
// Shares the single MIPS memory port between two requesters:
//   requester 0 : multi-cycle MIPS core (instruction and data accesses)
//   requester 1 : program loader / debug port
//
// Arbitration is round-robin with a bounded burst. The grant is decided
// combinationally in the cycle the request is presented, and the granted
// access drives the memory port in that same cycle. Accesses are
// single-beat. Read data comes back from memory RD_LATENCY cycles later and
// is routed to the requester that issued the read, using a small tag pipe.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req0/we0/addr0/wdata0    core request (held until gnt0)
//   gnt0                     core access accepted this cycle
//   rvalid0/rdata0           core read response
//   req1/we1/addr1/wdata1    loader request (held until gnt1)
//   gnt1                     loader access accepted this cycle
//   rvalid1/rdata1           loader read response
//   mem_addr/mem_wr_data     memory address / write data (0 when idle)
//   mem_wr_en                memory write strobe
//   mem_rd_data              memory read data, RD_LATENCY cycles after read
//   busy                     at least one read still in flight
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,   // 1..4
    parameter int MAX_BURST  = 4    // 1..15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,

    output logic                  busy
);

    // burst counter is 4 bits wide: enough for the largest legal MAX_BURST
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Arbitration state
    // -----------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic       last_reg,  last_next;    // owner of the most recent grant
    logic [3:0] burst_reg, burst_next;   // consecutive grants to current owner

    logic       grant0;
    logic       grant1;
    logic [3:0] burst_inc;

    // saturating increment so a long lone-requester run cannot wrap
    assign burst_inc = (burst_reg >= BURST_LIMIT) ? BURST_LIMIT : burst_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;      // core wins the first tie after reset
            burst_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            burst_reg <= burst_next;
        end
    end

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = IDLE;
        last_next  = last_reg;
        burst_next = 4'd0;

        if (!rst) begin
            if (req0 && req1) begin
                // contention: the owner keeps the port until its burst is
                // used up, then the waiting requester takes over
                unique case (state_reg)
                    OWN0: begin
                        if (burst_reg < BURST_LIMIT) grant0 = 1'b1;
                        else                         grant1 = 1'b1;
                    end
                    OWN1: begin
                        if (burst_reg < BURST_LIMIT) grant1 = 1'b1;
                        else                         grant0 = 1'b1;
                    end
                    default: begin
                        if (last_reg) grant0 = 1'b1;
                        else          grant1 = 1'b1;
                    end
                endcase
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end

        if (grant0) begin
            state_next = OWN0;
            last_next  = 1'b0;
            burst_next = (state_reg == OWN0) ? burst_inc : 4'd1;
        end else if (grant1) begin
            state_next = OWN1;
            last_next  = 1'b1;
            burst_next = (state_reg == OWN1) ? burst_inc : 4'd1;
        end
    end

    assign gnt0 = grant0;
    assign gnt1 = grant1;

    // -----------------------------------------------------------------------
    // Memory port: driven directly by the granted requester, zero otherwise
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        if (grant0) begin
            mem_addr    = addr0;
            mem_wr_data = wdata0;
            mem_wr_en   = we0;
        end else if (grant1) begin
            mem_addr    = addr1;
            mem_wr_data = wdata1;
            mem_wr_en   = we1;
        end
    end

    // -----------------------------------------------------------------------
    // Read tag pipe: one stage per cycle of memory latency. Stage 0 receives
    // the tag of the current cycle's access; the last stage lines up with
    // mem_rd_data for that access.
    // -----------------------------------------------------------------------
    logic [RD_LATENCY-1:0] pipe_valid_reg, pipe_valid_next;
    logic [RD_LATENCY-1:0] pipe_owner_reg, pipe_owner_next;

    assign pipe_valid_next[0] = (grant0 && !we0) || (grant1 && !we1);
    assign pipe_owner_next[0] = grant1;

    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
            assign pipe_owner_next[gi] = pipe_owner_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            // discards any read in flight so no stale response follows reset
            pipe_valid_reg <= '0;
            pipe_owner_reg <= '0;
        end else begin
            pipe_valid_reg <= pipe_valid_next;
            pipe_owner_reg <= pipe_owner_next;
        end
    end

    logic rsp_valid;
    logic rsp_owner;

    // gated with rst so responses and busy drop in the reset cycle itself
    assign rsp_valid = pipe_valid_reg[RD_LATENCY-1] && !rst;
    assign rsp_owner = pipe_owner_reg[RD_LATENCY-1];

    assign rvalid0 = rsp_valid && !rsp_owner;
    assign rvalid1 = rsp_valid &&  rsp_owner;
    assign rdata0  = rvalid0 ? mem_rd_data : '0;
    assign rdata1  = rvalid1 ? mem_rd_data : '0;

    assign busy = (|pipe_valid_reg) && !rst;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mips_mem_arbiter (RD_LATENCY=2, MAX_BURST=4).
// A table of per-cycle vectors checks grants, the memory port and busy;
// hand-written sequences cover burst rotation, a lone requester and reset
// in the middle of a read. Read responses are checked by a scoreboard queue
// filled when a read grant is expected and drained by a response monitor.
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    localparam int LAT   = 2;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    mips_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(LAT), .MAX_BURST(BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    // ---------------- memory model (fixed read latency LAT) ----------------
    logic [31:0] mem_model [4096];
    logic [31:0] rd_addr_pipe [LAT];

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'hA5A5_0000 + 32'(i);
        mem_model[12'h040] = 32'h1234_5678;
        mem_model[12'h010] = 32'h0000_000A;
        mem_model[12'h020] = 32'h0000_000B;
        mem_model[12'h030] = 32'h0000_000C;
        for (int i = 0; i < LAT; i++) rd_addr_pipe[i] = 32'h0;
    end

    always @(posedge clk) begin
        rd_addr_pipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) rd_addr_pipe[i] <= rd_addr_pipe[i-1];
        if (mem_wr_en) mem_model[mem_addr[11:0]] <= mem_wr_data;
    end

    assign mem_rd_data = mem_model[rd_addr_pipe[LAT-1][11:0]];

    // ---------------- counters and compare helper ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- response scoreboard ----------------
    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t sb[$];

    task automatic expect_read(input logic owner, input logic [31:0] data);
        rsp_t e;
        e.owner = owner;
        e.data  = data;
        e.due   = cyc + LAT;
        sb.push_back(e);
        $display("push read owner=%0d data=%h due=%0d", owner, data, e.due);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        chk("single_rvalid", 32'(rvalid0 & rvalid1), 32'h0);
        if (!rvalid0) chk("rdata0_idle", rdata0, 32'h0);
        if (!rvalid1) chk("rdata1_idle", rdata1, 32'h0);
        if (rvalid0 || rvalid1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rvalid @cycle %0d: rvalid0=%0b rvalid1=%0b, expected none",
                         cyc, rvalid0, rvalid1);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 32'(rvalid1), 32'(e.owner));
                chk("rsp_data", rvalid1 ? rdata1 : rdata0, e.data);
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                $display("rsp owner=%0d data=%h cycle=%0d", rvalid1, rvalid1 ? rdata1 : rdata0, cyc);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_rvalid @cycle %0d: got no response, expected owner %0d data %h",
                     cyc, e.owner, e.data);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1;     // expected grants
        logic [31:0] rdx;        // expected read data if a read is granted
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                                input logic r1, w1, input logic [31:0] a1, d1,
                                input logic g0, g1, input logic [31:0] rdx);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rdx = rdx;
        return v;
    endfunction

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        repeat (n) next_cycle();
    endtask

    logic [LAT-1:0] rd_hist;
    logic           rd_now;
    logic [31:0]    exp_addr, exp_data;
    logic           exp_we;
    logic [1:0]     burst_pat [10];

    initial begin
        // ---- reset with requests pending: everything quiet ----
        req0 = 1; addr0 = 32'h40;
        req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_busy", 32'(busy), 0);

        // ---- table ----
        //         r0 w0 a0      d0      r1 w1 a1      d1            g0 g1 rdx
        vt.push_back(mk(1, 0, 32'h40, 0,    0, 0, 0,      0,            1, 0, 32'h1234_5678));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0,      0,    1, 1, 32'h100, 32'hDEAD_BEEF, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(1, 0, 32'h10, 0,    1, 0, 32'h20, 0,            1, 0, 32'hA));
        vt.push_back(mk(0, 0, 0,      0,    1, 0, 32'h20, 0,            0, 1, 32'hB));
        vt.push_back(mk(1, 0, 32'h30, 0,    0, 0, 0,      0,            1, 0, 32'hC));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0,      0,    1, 0, 32'h100, 0,           0, 1, 32'hDEAD_BEEF));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(1, 1, 32'h200, 32'h11, 1, 1, 32'h300, 32'h22,  1, 0, 0));
        vt.push_back(mk(0, 0, 0,      0,    1, 1, 32'h300, 32'h22,      0, 1, 0));
        vt.push_back(mk(1, 0, 32'h40, 0,    1, 0, 32'h44, 0,            0, 1, 32'hA5A5_0044));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));
        vt.push_back(mk(1, 0, 32'h40, 0,    0, 0, 0,      0,            1, 0, 32'h1234_5678));
        vt.push_back(mk(0, 0, 0,      0,    0, 0, 0,      0,            0, 0, 0));

        rd_hist = '0;
        for (int k = 0; k < vt.size(); k++) begin
            next_cycle();
            rst    = 0;
            req0   = vt[k].r0; we0 = vt[k].w0; addr0 = vt[k].a0; wdata0 = vt[k].d0;
            req1   = vt[k].r1; we1 = vt[k].w1; addr1 = vt[k].a1; wdata1 = vt[k].d1;
            rd_now = (vt[k].g0 && !vt[k].w0) || (vt[k].g1 && !vt[k].w1);
            if (rd_now) expect_read(vt[k].g1, vt[k].rdx);
            exp_addr = vt[k].g0 ? vt[k].a0 : (vt[k].g1 ? vt[k].a1 : 32'h0);
            exp_data = vt[k].g0 ? vt[k].d0 : (vt[k].g1 ? vt[k].d1 : 32'h0);
            exp_we   = vt[k].g0 ? vt[k].w0 : (vt[k].g1 ? vt[k].w1 : 1'b0);
            @(negedge clk);
            $display("vec %0d: gnt0=%0b gnt1=%0b addr=%h wdata=%h we=%0b busy=%0b",
                     k, gnt0, gnt1, mem_addr, mem_wr_data, mem_wr_en, busy);
            chk("vec_gnt0", 32'(gnt0), 32'(vt[k].g0));
            chk("vec_gnt1", 32'(gnt1), 32'(vt[k].g1));
            chk("vec_mem_addr", mem_addr, exp_addr);
            chk("vec_mem_wdata", mem_wr_data, exp_data);
            chk("vec_mem_wr_en", 32'(mem_wr_en), 32'(exp_we));
            chk("vec_busy", 32'(busy), 32'(|rd_hist));
            rd_hist = LAT'((rd_hist << 1) | LAT'(rd_now));
        end
        idle_cycles(LAT + 2);

        // ---- burst rotation from a fresh reset: 0,0,0,0,1,1,1,1,0,0 ----
        burst_pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        rst = 1;
        repeat (2) next_cycle();
        rst = 0;
        req0 = 1; we0 = 1; addr0 = 32'h500; wdata0 = 32'h5;
        req1 = 1; we1 = 1; addr1 = 32'h600; wdata1 = 32'h6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            $display("burst %0d: gnt0=%0b gnt1=%0b addr=%h", i, gnt0, gnt1, mem_addr);
            chk("burst_gnt", {30'h0, gnt1, gnt0}, 32'(burst_pat[i]));
            chk("burst_addr", mem_addr, burst_pat[i] == 2'd1 ? 32'h500 : 32'h600);
            next_cycle();
        end
        idle_cycles(1);

        // ---- lone loader reads for 10 cycles: grant every cycle ----
        for (int i = 0; i < 10; i++) begin
            req1 = 1; we1 = 0; addr1 = 32'h800 + 32'(4 * i);
            expect_read(1'b1, 32'hA5A5_0000 + 32'h800 + 32'(4 * i));
            @(negedge clk);
            $display("lone %0d: gnt1=%0b addr=%h", i, gnt1, mem_addr);
            chk("lone_gnt1", 32'(gnt1), 1);
            chk("lone_gnt0", 32'(gnt0), 0);
            next_cycle();
        end
        idle_cycles(LAT + 2);

        // ---- reset right after a granted core read ----
        req0 = 1; we0 = 0; addr0 = 32'h40;
        @(negedge clk);
        chk("rr_gnt0", 32'(gnt0), 1);
        next_cycle();
        rst = 1; addr0 = 32'h48;
        @(negedge clk);
        $display("reset cycle: gnt0=%0b addr=%h busy=%0b", gnt0, mem_addr, busy);
        chk("rr_rst_gnt0", 32'(gnt0), 0);
        chk("rr_rst_addr", mem_addr, 0);
        chk("rr_rst_busy", 32'(busy), 0);
        next_cycle();
        rst = 0;
        idle_inputs();
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("rr_post_busy", 32'(busy), 0);
            next_cycle();
        end
        req0 = 1; we0 = 0; addr0 = 32'h50;
        expect_read(1'b0, 32'hA5A5_0050);
        @(negedge clk);
        $display("after reset: gnt0=%0b addr=%h", gnt0, mem_addr);
        chk("rr_regrant", 32'(gnt0), 1);
        chk("rr_regrant_addr", mem_addr, 32'h50);
        next_cycle();
        idle_cycles(LAT + 2);

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
